// File: rtl/bcd_subtractor_serial_if.sv
// Handshake and operand/result bundle for bcd_subtractor_serial.
//   start  : request (master -> slave), sampled only while the slave is idle
//   A, B   : packed BCD minuend / subtrahend, digit 0 in bits [3:0]
//   b0     : borrow in
//   busy   : slave is processing digits
//   done   : one-cycle pulse, D/borrow/error valid
//   D      : packed BCD difference (ten's complement when borrow=1)
//   borrow : borrow out of the most significant digit
//   error  : an operand digit was greater than 9
interface bcd_subtractor_serial_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  b0;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   D;
  logic                  borrow;
  logic                  error;

  modport master (
    output start, A, B, b0,
    input  busy, done, D, borrow, error
  );

  modport slave (
    input  start, A, B, b0,
    output busy, done, D, borrow, error
  );
endinterface

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor: D = A - B - b0, one digit per clock, LSD first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, aborts any operation in progress
//   bus   : bcd_subtractor_serial_if slave modport (start/A/B/b0 in,
//           busy/done/D/borrow/error out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one digit per cycle, borrow rippling through br_q
// DONE  | done pulse; D/borrow/error freshly updated; back to IDLE
module bcd_subtractor_serial #(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_subtractor_serial_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            br_q, br_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            borrow_q, borrow_d;
  logic            error_q, error_d;

  logic            operand_bad;
  logic signed [5:0] t;
  logic signed [5:0] t_adj;
  logic [3:0]      digit;
  logic [W-1:0]    res_shift;

  always_comb begin
    operand_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.A[4*i +: 4] > 4'd9 || bus.B[4*i +: 4] > 4'd9) begin
        operand_bad = 1'b1;
      end
    end
  end

  // |t| <= 10, so 6-bit signed never overflows; a negative t is folded
  // back into 0..9 by adding 10 and produces the next borrow.
  always_comb begin
    t         = $signed({2'b00, a_q[3:0]}) - $signed({2'b00, b_q[3:0]})
                - $signed({5'b00000, br_q});
    t_adj     = t + 6'sd10;
    digit     = t[5] ? t_adj[3:0] : t[3:0];
    // New digit enters at the top so digit 0 ends up in bits [3:0].
    res_shift = (res_q >> 4) | (W'(digit) << (W - 4));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    br_d     = br_q;
    res_d    = res_q;
    dout_d   = dout_q;
    borrow_d = borrow_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = bus.A;
          b_d   = bus.B;
          br_d  = bus.b0;
          cnt_d = '0;
          res_d = '0;
          if (operand_bad) begin
            state_d  = DONE;
            dout_d   = '0;
            borrow_d = 1'b0;
            error_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        br_d  = t[5];
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) begin
          state_d  = DONE;
          dout_d   = res_shift;
          borrow_d = t[5];
          error_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      res_q    <= '0;
      dout_q   <= '0;
      borrow_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      br_q     <= br_d;
      res_q    <= res_d;
      dout_q   <= dout_d;
      borrow_q <= borrow_d;
      error_q  <= error_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.D      = dout_q;
  assign bus.borrow = borrow_q;
  assign bus.error  = error_q;

endmodule
